rx_bit_timer: RTL

Parametrised receive bit/byte timer for the USB receive path. Generates a one-cycle sample strobe at a configurable phase of each bit period, counts sampled bits into bytes, and counts bytes per packet. Adds bit-stuff skipping, edge resynchronisation and byte counting with overflow. Sits between the receive edge detector and the receive shift register / RX controller FSM.

---
 rtl/rx_bit_timer.sv | 105 ++++++++++
 1 files changed

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: USB receive bit/byte timer producing the sample strobe, bit index and per-packet byte count.
// Optional feature: define RX_BIT_TIMER_RESYNC_EN to let resync realign the bit period.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_PHASE  = 3,
  parameter int BITS_PER_BYTE = 8,
  localparam int PHASE_W      = $clog2(CLKS_PER_BIT + 1),
  localparam int BIT_W        = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable_timer,
  input  logic             resync,
  input  logic             skip_bit,
  output logic             shift_enable,
  output logic             byte_received,
  output logic [BIT_W-1:0] bit_index,
  output logic [7:0]       byte_count,
  output logic             byte_ovf
);

  localparam logic [PHASE_W-1:0] SAMPLE_P   = PHASE_W'(SAMPLE_PHASE);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CLKS_PER_BIT);
  localparam logic [PHASE_W-1:0] FIRST_P    = PHASE_W'(1);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(BITS_PER_BYTE - 1);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic [BIT_W-1:0]   bit_cnt;
  logic               enable_q;
  logic               resync_hit;
  logic               count_shift;
  logic               byte_done;
  logic               enable_rise;

`ifdef RX_BIT_TIMER_RESYNC_EN
  assign resync_hit = resync;
`else
  logic unused_resync;
  assign unused_resync = resync;
  assign resync_hit    = 1'b0;
`endif

  assign shift_enable = enable_timer && (phase == SAMPLE_P);
  assign count_shift  = shift_enable && !skip_bit;
  assign byte_done    = count_shift && (bit_cnt == LAST_BIT);
  assign enable_rise  = enable_timer && !enable_q;
  assign bit_index    = bit_cnt;

  // Phase 0 means idle; a resync restarts the period even on the wrap cycle.
  always_comb begin
    phase_next = '0;
    if (enable_timer) begin
      if (resync_hit || (phase == '0) || (phase == LAST_PHASE)) begin
        phase_next = FIRST_P;
      end else begin
        phase_next = phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase    <= '0;
      enable_q <= 1'b0;
    end else begin
      phase    <= phase_next;
      enable_q <= enable_timer;
    end
  end

  // Dropping enable discards any partial byte.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt       <= '0;
      byte_received <= 1'b0;
    end else if (!enable_timer) begin
      bit_cnt       <= '0;
      byte_received <= 1'b0;
    end else begin
      byte_received <= byte_done;
      if (count_shift) begin
        bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // Count and overflow persist while disabled so the controller can read them.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_count <= 8'd0;
      byte_ovf   <= 1'b0;
    end else if (enable_rise) begin
      byte_count <= 8'd0;
      byte_ovf   <= 1'b0;
    end else if (byte_done) begin
      if (byte_count == 8'hFF) begin
        byte_ovf <= 1'b1;
      end else begin
        byte_count <= byte_count + 8'd1;
      end
    end
  end

endmodule
